// File: rtl/ml_alert_filter.sv
// Post-inference alert filter: confidence/persistence qualification, single pending alert with ack,
// post-ack cooldown, FLASH_CRASH fast path and saturating per-class telemetry counters.
module ml_alert_filter #(
    parameter logic [7:0]  CONF_THRESH = 8'd64,
    parameter logic [7:0]  CRIT_CONF   = 8'd128,
    parameter int unsigned PERSIST     = 2,
    parameter int unsigned COOLDOWN    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ml_class,
    input  logic [7:0]  ml_confidence,
    input  logic        ml_valid,
    input  logic        alert_ack,
    input  logic [2:0]  cnt_sel,
    output logic        alert_valid,
    output logic        alert_pending,
    output logic [2:0]  alert_class,
    output logic [7:0]  alert_conf,
    output logic        alert_critical,
    output logic        cooldown_active,
    output logic [15:0] cnt_value
);

    localparam logic [3:0]  PERSIST_N  = 4'(PERSIST);
    localparam logic [15:0] COOLDOWN_N = 16'(COOLDOWN);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ALERT, S_COOLDOWN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cand_q, cand_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  maxc_q, maxc_d;
    logic [15:0] timer_q, timer_d;
    logic        alert_valid_q, alert_valid_d;
    logic [2:0]  alert_class_q, alert_class_d;
    logic [7:0]  alert_conf_q, alert_conf_d;
    logic        alert_critical_q, alert_critical_d;
    logic [15:0] cnt_value_q, cnt_value_d;
    logic [15:0] cnt_q [6];
    logic [15:0] cnt_d [6];

    logic       qual, crit;
    logic [7:0] streak_max;
    logic       issue, issue_crit;
    logic [2:0] issue_class;
    logic [7:0] issue_conf;

    assign qual = ml_valid && (ml_class >= 3'd1) && (ml_class <= 3'd5)
                  && (ml_confidence >= CONF_THRESH);
    assign crit = ml_valid && (ml_class == 3'd3) && (ml_confidence >= CRIT_CONF);
    assign streak_max = (ml_confidence > maxc_q) ? ml_confidence : maxc_q;

    always_comb begin
        state_d          = state_q;
        cand_d           = cand_q;
        streak_d         = streak_q;
        maxc_d           = maxc_q;
        timer_d          = timer_q;
        alert_valid_d    = 1'b0;
        alert_class_d    = alert_class_q;
        alert_conf_d     = alert_conf_q;
        alert_critical_d = alert_critical_q;
        issue            = 1'b0;
        issue_class      = 3'd0;
        issue_conf       = 8'd0;
        issue_crit       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (qual) begin
                    cand_d   = ml_class;
                    streak_d = 4'd1;
                    maxc_d   = ml_confidence;
                    if (crit || PERSIST_N == 4'd1) begin
                        issue       = 1'b1;
                        issue_class = ml_class;
                        issue_conf  = ml_confidence;
                        issue_crit  = crit;
                    end else begin
                        state_d = S_TRACK;
                    end
                end
            end
            S_TRACK: begin
                if (crit) begin
                    // A critical sample extending a class-3 streak reports the streak maximum.
                    issue       = 1'b1;
                    issue_class = 3'd3;
                    issue_conf  = (cand_q == 3'd3) ? streak_max : ml_confidence;
                    issue_crit  = 1'b1;
                end else if (qual && ml_class == cand_q) begin
                    streak_d = streak_q + 4'd1;
                    maxc_d   = streak_max;
                    if (streak_q + 4'd1 == PERSIST_N) begin
                        issue       = 1'b1;
                        issue_class = cand_q;
                        issue_conf  = streak_max;
                    end
                end else if (qual) begin
                    cand_d   = ml_class;
                    streak_d = 4'd1;
                    maxc_d   = ml_confidence;
                end else if (ml_valid) begin
                    state_d  = S_IDLE;
                    streak_d = 4'd0;
                end
            end
            S_ALERT: begin
                if (crit && !alert_critical_q) begin
                    issue       = 1'b1;
                    issue_class = 3'd3;
                    issue_conf  = ml_confidence;
                    issue_crit  = 1'b1;
                end else if (alert_ack) begin
                    state_d = (COOLDOWN_N == 16'd0) ? S_IDLE : S_COOLDOWN;
                    timer_d = COOLDOWN_N;
                end
            end
            S_COOLDOWN: begin
                streak_d = 4'd0;
                if (crit) begin
                    issue       = 1'b1;
                    issue_class = 3'd3;
                    issue_conf  = ml_confidence;
                    issue_crit  = 1'b1;
                end else if (timer_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            state_d          = S_ALERT;
            streak_d         = 4'd0;
            timer_d          = 16'd0;
            alert_valid_d    = 1'b1;
            alert_class_d    = issue_class;
            alert_conf_d     = issue_conf;
            alert_critical_d = issue_crit;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_cnt
            assign cnt_d[gi] = (ml_valid && ml_class == 3'(gi) && cnt_q[gi] != 16'hFFFF)
                               ? cnt_q[gi] + 16'd1 : cnt_q[gi];
        end
    endgenerate

    assign cnt_value_d = (cnt_sel <= 3'd5) ? cnt_q[cnt_sel] : 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cand_q           <= 3'd0;
            streak_q         <= 4'd0;
            maxc_q           <= 8'd0;
            timer_q          <= 16'd0;
            alert_valid_q    <= 1'b0;
            alert_class_q    <= 3'd0;
            alert_conf_q     <= 8'd0;
            alert_critical_q <= 1'b0;
            cnt_value_q      <= 16'd0;
            for (int i = 0; i < 6; i++) cnt_q[i] <= 16'd0;
        end else begin
            state_q          <= state_d;
            cand_q           <= cand_d;
            streak_q         <= streak_d;
            maxc_q           <= maxc_d;
            timer_q          <= timer_d;
            alert_valid_q    <= alert_valid_d;
            alert_class_q    <= alert_class_d;
            alert_conf_q     <= alert_conf_d;
            alert_critical_q <= alert_critical_d;
            cnt_value_q      <= cnt_value_d;
            for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign alert_valid     = alert_valid_q;
    assign alert_pending   = (state_q == S_ALERT);
    assign alert_class     = alert_class_q;
    assign alert_conf      = alert_conf_q;
    assign alert_critical  = alert_critical_q;
    assign cooldown_active = (state_q == S_COOLDOWN);
    assign cnt_value       = cnt_value_q;

endmodule

// File: tb/tb_ml_alert_filter.sv
// Bench for ml_alert_filter: directed scenarios plus random traffic, every cycle compared
// against a streak-queue / deadline based reference model.
module tb_ml_alert_filter;

    localparam int PERSIST     = 2;
    localparam int COOLDOWN    = 1000;
    localparam int CONF_THRESH = 64;
    localparam int CRIT_CONF   = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ml_class;
    logic [7:0]  ml_confidence;
    logic        ml_valid;
    logic        alert_ack;
    logic [2:0]  cnt_sel;
    logic        alert_valid;
    logic        alert_pending;
    logic [2:0]  alert_class;
    logic [7:0]  alert_conf;
    logic        alert_critical;
    logic        cooldown_active;
    logic [15:0] cnt_value;

    always #5 clk = ~clk;

    ml_alert_filter #(
        .CONF_THRESH (8'(CONF_THRESH)),
        .CRIT_CONF   (8'(CRIT_CONF)),
        .PERSIST     (PERSIST),
        .COOLDOWN    (COOLDOWN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ml_class        (ml_class),
        .ml_confidence   (ml_confidence),
        .ml_valid        (ml_valid),
        .alert_ack       (alert_ack),
        .cnt_sel         (cnt_sel),
        .alert_valid     (alert_valid),
        .alert_pending   (alert_pending),
        .alert_class     (alert_class),
        .alert_conf      (alert_conf),
        .alert_critical  (alert_critical),
        .cooldown_active (cooldown_active),
        .cnt_value       (cnt_value)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: open streak kept as a queue of confidences, cooldown as an absolute deadline.
    int n_edge = 0;
    bit m_pending, m_valid, m_crit, m_cooling;
    int m_class, m_conf, m_cool_end, m_cand, m_cnt_value;
    int m_streak[$];
    int m_cnt[6];

    function automatic void m_reset();
        m_pending = 0; m_valid = 0; m_crit = 0; m_cooling = 0;
        m_class = 0; m_conf = 0; m_cool_end = 0; m_cand = 0; m_cnt_value = 0;
        m_streak.delete();
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    endfunction

    function automatic void m_fire(int c, int f, bit cr);
        m_pending = 1; m_valid = 1;
        m_class = c; m_conf = f; m_crit = cr;
        m_cooling = 0;
        m_streak.delete();
    endfunction

    function automatic void m_step(bit v, int c, int f, bit a, int s);
        bit q, cr;
        int cv, mx;
        n_edge++;
        q  = v && c >= 1 && c <= 5 && f >= CONF_THRESH;
        cr = v && c == 3 && f >= CRIT_CONF;
        cv = (s <= 5) ? m_cnt[s] : 0;
        if (v && c <= 5) begin
            if (m_cnt[c] < 65535) m_cnt[c]++;
        end
        m_valid = 0;
        if (m_pending) begin
            if (cr && !m_crit) m_fire(3, f, 1);
            else if (a) begin
                m_pending = 0;
                if (COOLDOWN > 0) begin
                    m_cooling  = 1;
                    m_cool_end = n_edge + COOLDOWN + 1;
                end
            end
        end else if (m_cooling) begin
            if (cr) m_fire(3, f, 1);
            else if (n_edge == m_cool_end) m_cooling = 0;
        end else begin
            if (cr) begin
                mx = f;
                if (m_cand == 3) foreach (m_streak[i]) if (m_streak[i] > mx) mx = m_streak[i];
                m_fire(3, mx, 1);
            end else if (q) begin
                if (m_streak.size() > 0 && c != m_cand) m_streak.delete();
                m_cand = c;
                m_streak.push_back(f);
                if (m_streak.size() == PERSIST) begin
                    mx = 0;
                    foreach (m_streak[i]) if (m_streak[i] > mx) mx = m_streak[i];
                    m_fire(c, mx, 0);
                end
            end else if (v) begin
                m_streak.delete();
            end
        end
        m_cnt_value = cv;
    endfunction

    task automatic step(input bit v, input int c, input int f, input bit a, input int s);
        ml_valid      = v;
        ml_class      = c[2:0];
        ml_confidence = f[7:0];
        alert_ack     = a;
        cnt_sel       = s[2:0];
        @(posedge clk);
        if (rst) m_reset();
        else m_step(v, c, f, a, s);
        #1;
        check("alert_valid", 32'(alert_valid), 32'(m_valid));
        check("alert_pending", 32'(alert_pending), 32'(m_pending));
        check("alert_class", 32'(alert_class), 32'(m_class));
        check("alert_conf", 32'(alert_conf), 32'(m_conf));
        check("alert_critical", 32'(alert_critical), 32'(m_crit));
        check("cooldown_active", 32'(cooldown_active), 32'(m_cooling));
        check("cnt_value", 32'(cnt_value), 32'(m_cnt_value));
        if (alert_valid)
            $display("alert t=%0t class=%0d conf=%0d critical=%0d",
                     $time, alert_class, alert_conf, alert_critical);
    endtask

    task automatic idle(input int n, input int s);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, s);
    endtask

    initial begin
        rst = 1'b1;
        m_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(2, 0);

        // Two qualified class-1 samples form an alert one clock after the second.
        step(1, 1, 100, 0, 0);
        step(1, 1, 150, 0, 0);
        check("t2_valid", 32'(alert_valid), 32'd1);
        check("t2_class", 32'(alert_class), 32'd1);
        check("t2_conf", 32'(alert_conf), 32'd150);
        check("t2_crit", 32'(alert_critical), 32'd0);
        idle(2, 0);

        // Reset while pending drops everything.
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t1_pending", 32'(alert_pending), 32'd0);
        check("t1_class", 32'(alert_class), 32'd0);
        check("t1_conf", 32'(alert_conf), 32'd0);
        rst = 1'b0;
        idle(3, 0);

        // Class change restarts the streak; max conf over the streak is reported.
        step(1, 2, 100, 0, 0);
        step(1, 4, 100, 0, 0);
        step(1, 4, 90, 0, 0);
        check("t3_class", 32'(alert_class), 32'd4);
        check("t3_conf", 32'(alert_conf), 32'd100);
        step(0, 0, 0, 1, 0);
        idle(COOLDOWN + 5, 0);
        step(1, 1, 30, 0, 0);
        step(1, 1, 200, 0, 0);
        idle(1, 0);
        check("t3_no_alert", 32'(alert_pending), 32'd0);
        step(1, 0, 0, 0, 0);

        // Critical fast path from IDLE, cooldown suppression, critical pre-emption of cooldown.
        step(1, 3, 200, 0, 0);
        check("t4_crit", 32'(alert_critical), 32'd1);
        step(0, 0, 0, 1, 0);
        idle(9, 0);
        step(1, 1, 100, 0, 0);
        idle(9, 0);
        step(1, 1, 100, 0, 0);
        idle(1, 0);
        check("t5_cool", 32'(cooldown_active), 32'd1);
        check("t5_no_alert", 32'(alert_pending), 32'd0);
        step(1, 3, 200, 0, 0);
        check("t5_preempt", 32'(alert_valid), 32'd1);
        step(0, 0, 0, 1, 0);
        idle(COOLDOWN + 5, 0);
        step(1, 1, 100, 0, 0);
        step(1, 1, 100, 0, 0);
        check("t5_after_cool", 32'(alert_valid), 32'd1);
        idle(1, 0);
        // Upgrade coincident with ack: the upgrade wins.
        step(1, 3, 200, 1, 0);
        check("t4_upgrade_class", 32'(alert_class), 32'd3);
        check("t4_upgrade_pending", 32'(alert_pending), 32'd1);
        step(0, 0, 0, 1, 0);

        // Telemetry counters and out-of-range select.
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 1, 10, 0, 0);
        idle(2, 0);
        check("t6_cnt0", 32'(cnt_value), 32'd5);
        idle(2, 1);
        check("t6_cnt1", 32'(cnt_value), 32'd2);
        idle(2, 7);
        check("t6_cnt7", 32'(cnt_value), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            int c, f;
            c = $urandom_range(0, 7);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 255);
            step(($urandom_range(0, 1) == 1), c, f, ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 7));
        end

        // Saturation of a counter.
        for (int i = 0; i < 65540; i++) step(1, 5, 0, 0, 5);
        idle(1, 5);
        check("t6_sat", 32'(cnt_value), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
